seven_seg_scroller: RTL and testbench
=====================================

# seven_seg_scroller

Scroll controller for the two-digit seven-segment display. Holds a short ASCII message written by a host, then sequences it right-to-left across both digits, one frame per step period. Drives the 8-bit character-code inputs of the two character-to-segment decoders (left digit = Segment1, right digit = Segment2). Supports pause, loop and stop.

## Interface
- CLKS_PER_STEP, 6250000, clock cycles per scroll frame (0.25 s at 25 MHz); must be ≥ 2
- MSG_DEPTH, 16, message buffer capacity in characters; power of two
- i_Clk  in  1  system clock, all logic on rising edge
- i_Rst  in  1  reset, asynchronous, active-high
- i_Wr_En  in  1  append i_Wr_Data to the message buffer
- i_Wr_Data  in  8  ASCII character to append
- i_Clear  in  1  empty the message buffer
- i_Start  in  1  begin scrolling (single-cycle pulse or level; edge not required)
- i_Stop  in  1  abort scrolling, return to idle
- i_Pause  in  1  level; freezes the step timer while high
- i_Loop  in  1  level; sampled at end of last frame, restarts instead of finishing
- o_Char_Left  out  8  ASCII code for left digit
- o_Char_Right  out  8  ASCII code for right digit
- o_Count  out  $clog2(MSG_DEPTH)+1  characters currently stored
- o_Full  out  1  o_Count == MSG_DEPTH
- o_Busy  out  1  high in SCROLL state
- o_Done  out  1  one-cycle pulse when a non-looping scroll completes

## Operation
- States: IDLE, SCROLL. Reset → IDLE.
- Reset values: o_Char_Left = o_Char_Right = 8'h20 (space), count 0, frame index 0, timer 0, o_Busy 0, o_Done 0.
- Buffer writes (IDLE only): i_Wr_En stores at index count, count increments. Ignored when full, in SCROLL, or coincident with i_Start or i_Clear. i_Clear in IDLE sets count to 0; buffer contents are not erased.
- IDLE → SCROLL on i_Start with count > 0; frame k = 0, timer = 0. i_Start with count 0 is ignored. i_Clear with i_Start in the same cycle: clear wins, start ignored.
- Frames k = 0..n (n = count, n+1 frames total): left = (k == 0) ? space : msg[k-1]; right = (k == n) ? space : msg[k].
- Timer counts 0..CLKS_PER_STEP-1 while i_Pause is low and holds while it is high. At terminal count it wraps to 0 and k increments.
- At terminal count with k == n:
  - i_Loop high: k = 0, stay in SCROLL.
  - i_Loop low: go to IDLE, both outputs set to space, o_Done pulses.
- i_Stop in SCROLL: go to IDLE next cycle, outputs set to space, no o_Done. i_Stop takes priority over a coincident terminal count.
- i_Start during SCROLL is ignored (no restart).
- Count is frozen during SCROLL, so message length cannot change mid-scroll.

## Timing
- All outputs are registered.
- i_Start sampled at edge 0; o_Busy high and frame 0 on the outputs after edge 0.
- Each frame is held for exactly CLKS_PER_STEP cycles, plus any cycles with i_Pause high.
- Non-looping scroll: o_Busy high for (n+1)·CLKS_PER_STEP cycles. o_Done is high in the first cycle after o_Busy falls and is never coincident with o_Busy.
- Write to count update: 1 cycle. o_Full follows count in the same cycle.
- Asynchronous reset mid-scroll: immediately forces IDLE and space outputs; the buffer is logically emptied (count 0).

## Structure
- Package seg_scroll_pkg: state enum (IDLE, SCROLL), ASCII_SPACE = 8'h20.
- Sub-module step_timer: parameter CLKS_PER_STEP; inputs clear and enable; output terminal-count pulse. Instantiated once.
- Message buffer is a register array inside seven_seg_scroller, with one write port and two combinational read ports (k-1, k).

## Test plan
All scenarios use CLKS_PER_STEP = 4.
- Write "HI", pulse i_Start, i_Loop 0 → frames (sp,H), (H,I), (I,sp), 4 cycles each; o_Busy high 12 cycles; o_Done pulses once; outputs return to (sp,sp).
- Write 17 chars with MSG_DEPTH 16 → o_Count = 16, o_Full = 1, 17th char dropped; pulse i_Clear → o_Count = 0, o_Full = 0.
- i_Start with empty buffer → o_Busy stays 0, outputs stay 8'h20.
- Write "A", i_Loop 1 → frames (sp,A), (A,sp), (sp,A) repeating with no o_Done; drop i_Loop and let the current pass end → o_Done pulses.
- Write "AB", hold i_Pause for 10 cycles during frame 1 → frame 1 lasts 14 cycles, total busy time 22 cycles.
- Assert i_Stop mid-frame 1 → next cycle o_Busy 0, outputs (sp,sp), no o_Done; assert i_Rst mid-scroll → immediate (sp,sp), o_Count 0.

Source files
------------

// File: rtl/seg_scroll_pkg.sv
// Shared types and constants for the seven-segment scroller.
// Exports the FSM state enum and the ASCII space code used as blank.
package seg_scroll_pkg;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        SCROLL = 1'b1
    } state_t;

    localparam logic [7:0] ASCII_SPACE = 8'h20;

endpackage

// File: rtl/seven_seg_scroller_step_timer.sv
// Frame step timer: counts 0..CLKS_PER_STEP-1 while enabled.
// Ports: i_Clk, i_Rst, clear (sync zero), enable (count), tc (last-count pulse).
module step_timer #(
    parameter int unsigned CLKS_PER_STEP = 6250000
) (
    input  logic i_Clk,
    input  logic i_Rst,
    input  logic clear,
    input  logic enable,
    output logic tc
);

    localparam int TW = $clog2(CLKS_PER_STEP);
    localparam logic [TW-1:0] LAST = TW'(CLKS_PER_STEP - 1);

    logic [TW-1:0] cnt;

    assign tc = enable && !clear && (cnt == LAST);

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= tc ? '0 : cnt + TW'(1);
        end
    end

endmodule

// File: rtl/seven_seg_scroller.sv
// Scrolls a host-written ASCII message right-to-left over two digits.
// Ports: i_Clk/i_Rst, write/clear/start/stop/pause/loop controls,
// o_Char_Left/o_Char_Right codes, o_Count/o_Full, o_Busy, o_Done.
module seven_seg_scroller
    import seg_scroll_pkg::*;
#(
    parameter int unsigned CLKS_PER_STEP = 6250000,
    parameter int unsigned MSG_DEPTH     = 16
) (
    input  logic                         i_Clk,
    input  logic                         i_Rst,
    input  logic                         i_Wr_En,
    input  logic [7:0]                   i_Wr_Data,
    input  logic                         i_Clear,
    input  logic                         i_Start,
    input  logic                         i_Stop,
    input  logic                         i_Pause,
    input  logic                         i_Loop,
    output logic [7:0]                   o_Char_Left,
    output logic [7:0]                   o_Char_Right,
    output logic [$clog2(MSG_DEPTH):0]   o_Count,
    output logic                         o_Full,
    output logic                         o_Busy,
    output logic                         o_Done
);

    localparam int AW = $clog2(MSG_DEPTH);
    localparam int CW = AW + 1;

    state_t        state;
    logic [CW-1:0] count;
    logic [CW-1:0] k;
    logic [7:0]    msg [MSG_DEPTH];

    logic          tc;
    logic          full;
    logic          wr_ok;
    logic          last_frame;
    logic [CW-1:0] k_nxt;
    logic [AW-1:0] rd_l;
    logic [AW-1:0] rd_r;
    logic [7:0]    left_nxt;
    logic [7:0]    right_nxt;

    step_timer #(
        .CLKS_PER_STEP(CLKS_PER_STEP)
    ) u_timer (
        .i_Clk (i_Clk),
        .i_Rst (i_Rst),
        .clear (state == IDLE || i_Stop),
        .enable(state == SCROLL && !i_Pause),
        .tc    (tc)
    );

    assign full       = (count == CW'(MSG_DEPTH));
    assign last_frame = (k == count);

    // Starts and clears take the cycle; a write alongside them is dropped.
    assign wr_ok = (state == IDLE) && i_Wr_En && !full
                 && !i_Start && !i_Clear;

    // Output registers load from the frame being entered, so the two
    // read ports are addressed by the next frame index.
    always_comb begin
        k_nxt = '0;
        if (state == SCROLL && tc && !last_frame) begin
            k_nxt = k + CW'(1);
        end
        rd_l      = AW'(k_nxt - CW'(1));
        rd_r      = k_nxt[AW-1:0];
        left_nxt  = (k_nxt == '0)    ? ASCII_SPACE : msg[rd_l];
        right_nxt = (k_nxt == count) ? ASCII_SPACE : msg[rd_r];
    end

    always_ff @(posedge i_Clk) begin
        if (wr_ok) begin
            msg[count[AW-1:0]] <= i_Wr_Data;
        end
    end

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state        <= IDLE;
            count        <= '0;
            k            <= '0;
            o_Char_Left  <= ASCII_SPACE;
            o_Char_Right <= ASCII_SPACE;
            o_Busy       <= 1'b0;
            o_Done       <= 1'b0;
        end else begin
            o_Done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (i_Clear) begin
                        count <= '0;
                    end else if (i_Start && count != '0) begin
                        state        <= SCROLL;
                        k            <= '0;
                        o_Busy       <= 1'b1;
                        o_Char_Left  <= left_nxt;
                        o_Char_Right <= right_nxt;
                    end else if (wr_ok) begin
                        count <= count + CW'(1);
                    end
                end
                SCROLL: begin
                    if (i_Stop) begin
                        state        <= IDLE;
                        k            <= '0;
                        o_Busy       <= 1'b0;
                        o_Char_Left  <= ASCII_SPACE;
                        o_Char_Right <= ASCII_SPACE;
                    end else if (tc && last_frame && !i_Loop) begin
                        state        <= IDLE;
                        k            <= '0;
                        o_Busy       <= 1'b0;
                        o_Done       <= 1'b1;
                        o_Char_Left  <= ASCII_SPACE;
                        o_Char_Right <= ASCII_SPACE;
                    end else if (tc) begin
                        k            <= k_nxt;
                        o_Char_Left  <= left_nxt;
                        o_Char_Right <= right_nxt;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign o_Count = count;
    assign o_Full  = full;

endmodule

// File: tb/tb_seven_seg_scroller.sv
// Directed self-checking bench for seven_seg_scroller (CLKS_PER_STEP = 4).
// Drives controls after each rising edge and samples 1 time unit later.
module tb_seven_seg_scroller;

    localparam int STEP  = 4;
    localparam int DEPTH = 16;

    logic       i_Clk = 1'b0;
    logic       i_Rst;
    logic       i_Wr_En;
    logic [7:0] i_Wr_Data;
    logic       i_Clear;
    logic       i_Start;
    logic       i_Stop;
    logic       i_Pause;
    logic       i_Loop;
    logic [7:0] o_Char_Left;
    logic [7:0] o_Char_Right;
    logic [4:0] o_Count;
    logic       o_Full;
    logic       o_Busy;
    logic       o_Done;

    int passed = 0;
    int total  = 0;

    seven_seg_scroller #(
        .CLKS_PER_STEP(STEP),
        .MSG_DEPTH    (DEPTH)
    ) dut (
        .i_Clk       (i_Clk),
        .i_Rst       (i_Rst),
        .i_Wr_En     (i_Wr_En),
        .i_Wr_Data   (i_Wr_Data),
        .i_Clear     (i_Clear),
        .i_Start     (i_Start),
        .i_Stop      (i_Stop),
        .i_Pause     (i_Pause),
        .i_Loop      (i_Loop),
        .o_Char_Left (o_Char_Left),
        .o_Char_Right(o_Char_Right),
        .o_Count     (o_Count),
        .o_Full      (o_Full),
        .o_Busy      (o_Busy),
        .o_Done      (o_Done)
    );

    always #5 i_Clk = ~i_Clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge i_Clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] c);
        i_Wr_En   = 1'b1;
        i_Wr_Data = c;
        step();
        i_Wr_En   = 1'b0;
    endtask

    task automatic start_scroll();
        i_Start = 1'b1;
        step();
        i_Start = 1'b0;
    endtask

    // Reference model of frame index and step timer; checks every cycle.
    task automatic run_scroll(input string m, input int drop_loop_at,
                              input int pause_at, input int pause_len,
                              input int stop_at, input int exp_cycles);
        int n = m.len();
        int k = 0;
        int t = 0;
        int c = 0;
        bit finished = 0;
        bit stopped = 0;
        logic [7:0] el;
        logic [7:0] er;
        while (!finished && !stopped && c < 200) begin
            i_Pause = (c >= pause_at) && (c < pause_at + pause_len);
            if (c == drop_loop_at) i_Loop = 1'b0;
            el = (k == 0) ? 8'h20 : m[k-1];
            er = (k == n) ? 8'h20 : m[k];
            chk("busy", o_Busy, 1);
            chk("left", o_Char_Left, el);
            chk("right", o_Char_Right, er);
            chk("done_mid", o_Done, 0);
            if (c == stop_at) begin
                i_Stop = 1'b1;
                step();
                i_Stop = 1'b0;
                chk("stop_busy", o_Busy, 0);
                chk("stop_left", o_Char_Left, 8'h20);
                chk("stop_right", o_Char_Right, 8'h20);
                chk("stop_done", o_Done, 0);
                step();
                chk("stop_done2", o_Done, 0);
                stopped = 1;
            end else begin
                if (!i_Pause) begin
                    if (t == STEP - 1) begin
                        t = 0;
                        if (k == n) begin
                            if (i_Loop) k = 0;
                            else finished = 1;
                        end else begin
                            k++;
                        end
                    end else begin
                        t++;
                    end
                end
                step();
                c++;
            end
        end
        i_Pause = 1'b0;
        if (!stopped) begin
            chk("busy_cycles", c, exp_cycles);
            chk("end_busy", o_Busy, 0);
            chk("end_done", o_Done, 1);
            chk("end_left", o_Char_Left, 8'h20);
            chk("end_right", o_Char_Right, 8'h20);
            step();
            chk("done_width", o_Done, 0);
        end
    endtask

    initial begin
        i_Rst     = 1'b1;
        i_Wr_En   = 1'b0;
        i_Wr_Data = 8'h00;
        i_Clear   = 1'b0;
        i_Start   = 1'b0;
        i_Stop    = 1'b0;
        i_Pause   = 1'b0;
        i_Loop    = 1'b0;
        step();
        step();
        i_Rst = 1'b0;
        step();

        chk("rst_left", o_Char_Left, 8'h20);
        chk("rst_right", o_Char_Right, 8'h20);
        chk("rst_count", o_Count, 0);
        chk("rst_full", o_Full, 0);
        chk("rst_busy", o_Busy, 0);
        chk("rst_done", o_Done, 0);

        wr("H");
        wr("I");
        chk("hi_count", o_Count, 2);
        start_scroll();
        run_scroll("HI", -1, -1, 0, -1, 12);

        i_Clear = 1'b1;
        step();
        i_Clear = 1'b0;
        chk("clr_count", o_Count, 0);
        for (int i = 0; i < 17; i++) wr(8'h61 + 8'(i));
        chk("full_count", o_Count, 16);
        chk("full_flag", o_Full, 1);
        i_Clear = 1'b1;
        step();
        i_Clear = 1'b0;
        chk("clr2_count", o_Count, 0);
        chk("clr2_full", o_Full, 0);

        start_scroll();
        chk("empty_busy", o_Busy, 0);
        chk("empty_left", o_Char_Left, 8'h20);
        chk("empty_right", o_Char_Right, 8'h20);
        step();
        chk("empty_busy2", o_Busy, 0);

        wr("Z");
        chk("z_count", o_Count, 1);
        i_Clear = 1'b1;
        i_Start = 1'b1;
        step();
        i_Clear = 1'b0;
        i_Start = 1'b0;
        chk("clrstart_busy", o_Busy, 0);
        chk("clrstart_count", o_Count, 0);

        wr("A");
        i_Loop = 1'b1;
        start_scroll();
        run_scroll("A", 17, -1, 0, -1, 24);

        i_Clear = 1'b1;
        step();
        i_Clear = 1'b0;
        wr("A");
        wr("B");
        start_scroll();
        run_scroll("AB", -1, 5, 10, -1, 22);

        start_scroll();
        run_scroll("AB", -1, -1, 0, 6, 0);
        chk("stop_count", o_Count, 2);

        start_scroll();
        step();
        step();
        step();
        step();
        step();
        chk("pre_rst_busy", o_Busy, 1);
        #2;
        i_Rst = 1'b1;
        #1;
        chk("arst_busy", o_Busy, 0);
        chk("arst_left", o_Char_Left, 8'h20);
        chk("arst_right", o_Char_Right, 8'h20);
        chk("arst_count", o_Count, 0);
        step();
        i_Rst = 1'b0;
        step();
        chk("post_rst_busy", o_Busy, 0);
        chk("post_rst_done", o_Done, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
